// File: rtl/radix4_booth_mul.sv
//------------------------------------------------------------------------------
// radix4_booth_mul : 8x8 signed radix-4 Booth multiplier, 8-stage pipeline,
//                    15-bit two's-complement product.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module radix4_booth_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [14:0] o_mul
);

  // S0 / S1
  logic [7:0]       r0_x, r0_y;
  logic [7:0]       r1_x, r1_y;
  logic [8:0]       r1_x2;
  // S2
  logic [3:0]       r2_neg, r2_one, r2_two;
  logic [7:0]       r2_x;
  logic [8:0]       r2_x2;
  // S3 .. S7
  logic [3:0][9:0]  r3_pp;
  logic [15:0]      r4_acc, r5_acc, r6_acc;
  logic [9:0]       r4_pp1, r4_pp2, r4_pp3;
  logic [9:0]       r5_pp2, r5_pp3;
  logic [9:0]       r6_pp3;
  logic [14:0]      r7_mul;

  logic [8:0]       w_trip;
  logic [3:0]       w_neg, w_one, w_two;
  logic [3:0][9:0]  w_mag, w_pp;
  logic [15:0]      w_sum;
  logic             w_unused_msb;

  // Triplets overlap by one bit; the appended zero is the implicit y[-1].
  assign w_trip = {r1_y, 1'b0};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_booth
      logic [2:0] w_b;
      assign w_b      = w_trip[2*i+2 : 2*i];
      assign w_neg[i] = w_b[2] & ~(w_b[1] & w_b[0]);
      assign w_one[i] = w_b[1] ^ w_b[0];
      assign w_two[i] = (w_b[2] & ~w_b[1] & ~w_b[0]) | (~w_b[2] & w_b[1] & w_b[0]);
    end

    for (genvar i = 0; i < 4; i++) begin : g_pp
      assign w_mag[i] = r2_two[i] ? {r2_x2[8], r2_x2} :
                        r2_one[i] ? {{2{r2_x[7]}}, r2_x} : 10'd0;
      // 10 bits are enough to hold -(2 * -128) = +256.
      assign w_pp[i]  = r2_neg[i] ? (~w_mag[i] + 10'd1) : w_mag[i];
    end
  endgenerate

  assign w_sum        = r6_acc + {r6_pp3, 6'b0};
  assign w_unused_msb = w_sum[15];

  always_ff @(posedge clk) begin
    if (rst) begin
      r0_x   <= '0;
      r0_y   <= '0;
      r1_x   <= '0;
      r1_y   <= '0;
      r1_x2  <= '0;
      r2_neg <= '0;
      r2_one <= '0;
      r2_two <= '0;
      r2_x   <= '0;
      r2_x2  <= '0;
      r3_pp  <= '0;
      r4_acc <= '0;
      r4_pp1 <= '0;
      r4_pp2 <= '0;
      r4_pp3 <= '0;
      r5_acc <= '0;
      r5_pp2 <= '0;
      r5_pp3 <= '0;
      r6_acc <= '0;
      r6_pp3 <= '0;
      r7_mul <= '0;
    end else begin
      r0_x   <= x;
      r0_y   <= y;
      r1_x   <= r0_x;
      r1_y   <= r0_y;
      r1_x2  <= {r0_x, 1'b0};
      r2_neg <= w_neg;
      r2_one <= w_one;
      r2_two <= w_two;
      r2_x   <= r1_x;
      r2_x2  <= r1_x2;
      r3_pp  <= w_pp;
      r4_acc <= {{6{r3_pp[0][9]}}, r3_pp[0]};
      r4_pp1 <= r3_pp[1];
      r4_pp2 <= r3_pp[2];
      r4_pp3 <= r3_pp[3];
      r5_acc <= r4_acc + {{4{r4_pp1[9]}}, r4_pp1, 2'b0};
      r5_pp2 <= r4_pp2;
      r5_pp3 <= r4_pp3;
      r6_acc <= r5_acc + {{2{r5_pp2[9]}}, r5_pp2, 4'b0};
      r6_pp3 <= r5_pp3;
      r7_mul <= w_sum[14:0];
    end
  end

  assign o_mul = r7_mul;

endmodule

`default_nettype wire

// File: tb/tb_radix4_booth_mul.sv
//------------------------------------------------------------------------------
// tb_radix4_booth_mul : bench for radix4_booth_mul (vector table, hand-written
//                       latency/reset sequences, random stream vs product model).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_radix4_booth_mul;

  logic        clk;
  logic        rst;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [14:0] o_mul;

  int n_cmp = 0;
  int n_bad = 0;

  // Products still in flight, oldest first; always 7 deep between steps.
  logic [14:0] q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[17];

  radix4_booth_mul dut (
    .clk   (clk),
    .rst   (rst),
    .x     (x),
    .y     (y),
    .o_mul (o_mul)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] prod(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[14:0];
  endfunction

  task automatic flush_model();
    q.delete();
    repeat (7) q.push_back(15'd0);
  endtask

  // Drive one cycle of inputs, clock, then compare against the product model.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic r);
    logic [14:0] e;
    x   = a;
    y   = b;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      flush_model();
      e = 15'd0;
    end else begin
      q.push_back(prod(a, b));
      e = q.pop_front();
    end
    check("model", o_mul, e);
  endtask

  initial begin
    logic [14:0] obs[12];
    logic [14:0] exp_tp;

    vecs[0]  = '{8'd1,   8'd1,   15'd1};
    vecs[1]  = '{8'd8,   8'd3,   15'd24};
    vecs[2]  = '{8'd15,  8'd15,  15'd225};
    vecs[3]  = '{8'd56,  8'd25,  15'd1400};
    vecs[4]  = '{8'd127, 8'd127, 15'd16129};
    vecs[5]  = '{8'd100, 8'd10,  15'd1000};
    vecs[6]  = '{8'd42,  8'd10,  15'd420};
    vecs[7]  = '{8'hFF,  8'hFF,  15'd1};
    vecs[8]  = '{8'hFF,  8'd1,   15'h7FFF};
    vecs[9]  = '{8'd1,   8'hFF,  15'h7FFF};
    vecs[10] = '{8'h80,  8'd1,   15'h7F80};
    vecs[11] = '{8'hAA,  8'h55,  15'h6372};
    vecs[12] = '{8'h55,  8'hAA,  15'h6372};
    vecs[13] = '{8'd0,   8'd0,   15'd0};
    vecs[14] = '{8'd1,   8'd0,   15'd0};
    vecs[15] = '{8'd0,   8'd1,   15'd0};
    vecs[16] = '{8'h80,  8'h80,  15'h4000};

    x = 8'd0; y = 8'd0; rst = 1'b1;
    flush_model();

    // Reset for two cycles, then zeros must keep o_mul at 0.
    step(8'd0, 8'd0, 1'b1);
    step(8'd0, 8'd0, 1'b1);
    check("reset_state", o_mul, 15'd0);
    for (int i = 0; i < 10; i++) begin
      step(8'd0, 8'd0, 1'b0);
      check("post_reset_zero", o_mul, 15'd0);
    end

    // Held operands: result settles after 8 cycles.
    for (int i = 0; i < 17; i++) begin
      repeat (8) step(vecs[i].a, vecs[i].b, 1'b0);
      check($sformatf("vec%0d", i), o_mul, vecs[i].exp);
    end

    // Back-to-back pairs: 12, 66, 4 on consecutive cycles, first at step 8.
    repeat (8) step(8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      case (i)
        0:       step(8'd4,  8'd3, 1'b0);
        1:       step(8'd11, 8'd6, 1'b0);
        2:       step(8'd2,  8'd2, 1'b0);
        default: step(8'd0,  8'd0, 1'b0);
      endcase
      obs[i] = o_mul;
    end
    for (int i = 0; i < 12; i++) begin
      exp_tp = (i == 7) ? 15'd12 : (i == 8) ? 15'd66 : (i == 9) ? 15'd4 : 15'd0;
      check($sformatf("latency_cyc%0d", i + 1), obs[i], exp_tp);
    end

    // Mid-stream reset with three products in flight; nonzero operands
    // are held during reset so that the reset, not the inputs, clears S0.
    repeat (8) step(8'd0, 8'd0, 1'b0);
    step(8'd7,  8'd9,  1'b0);
    step(8'd13, 8'hF3, 1'b0);
    step(8'h80, 8'h7F, 1'b0);
    step(8'd5,  8'd5,  1'b1);
    check("midreset_now", o_mul, 15'd0);
    for (int i = 0; i < 9; i++) begin
      step(8'd0, 8'd0, 1'b0);
      check("midreset_no_stale", o_mul, 15'd0);
    end

    // Random back-to-back stream with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(8'($urandom), 8'($urandom), ($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < 120; i++) begin
      step((i % 3 == 0) ? 8'h80 : 8'($urandom), (i % 5 == 0) ? 8'h80 : 8'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/radix4_booth_mul.md
Name: radix4_booth_mul

Overview:
- 8x8 signed multiplier built on radix-4 (modified) Booth encoding, fully pipelined.
- Accepts one operand pair per clock and produces a 15-bit two's-complement product with a fixed 8-cycle latency.
- Serves as the multiply stage of the CNN MACC datapath and feeds the downstream accumulator.
- Has no handshake; the output is the product of whatever pair was sampled 8 cycles earlier.

Parameters:
- None. Operand width is fixed at 8 bits, product width at 15 bits, and latency at 8 cycles.

Ports:
- clk  input  1  rising-edge clock for all registers.
- rst  input  1  synchronous, active-high reset; clears every pipeline register.
- x  input  8  signed multiplicand (two's complement).
- y  input  8  signed multiplier (two's complement); this operand is Booth-encoded.
- o_mul  output  15  registered product; equals (x*y)[14:0] as a two's-complement pattern.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high: rst is sampled only on the rising edge of clk.
- While rst=1 at an edge, all pipeline registers load 0, including o_mul.
- After reset releases, the flushed zeros propagate, so o_mul=0 until the first real result arrives.
- Reset asserted mid-operation discards all in-flight products on that edge.
- Latency is 8 register stages:
  - Operands sampled at rising edge k appear on o_mul after edge k+7.
  - Throughput is 1 result per cycle.
  - There is no stall and no enable.
- Required stage partition:
  - S0: input registers for x and y.
  - S1: register x, y and 2x (9-bit signed, x<<1).
  - S2: Booth-encode y with an implicit y[-1]=0, using triplets {y[1:0],0}, y[3:1], y[5:3], y[7:5]. This gives four digits d_i in {-2,-1,0,+1,+2}, each coded as neg/one/two.
  - S3: form partial products pp_i, each 10-bit signed: 0, x or 2x selected by a 3:1 mux, then negated when neg=1 (invert and add 1).
  - S4: acc = sign-extended pp0.
  - S5: acc += pp1<<2.
  - S6: acc += pp2<<4.
  - S7 (output register): o_mul = (acc + (pp3<<6))[14:0].
- Each stage forwards the partial products still needed by later stages alongside acc.
- Arithmetic rules:
  - All partial products are sign-extended to at least 16 bits before adding; this internal width avoids overflow.
  - o_mul is the low 15 bits of the exact 16-bit product.
  - The sole out-of-range case is x=y=-128: the exact product +16384 wraps, so o_mul = 15'h4000 (reads as -16384 if interpreted signed). This is required behaviour, not an error.
- Digit -2 with x=-128 gives +256; the 10-bit pp width holds this.
- Digit +2 with x=-128 gives -256, also in range.
- Results are a pure function of the operands; back-to-back different operands produce independent results in consecutive cycles.

Test Plan:
- Reset then hold: rst=1 for 2 cycles with x=y=0, release -> o_mul stays 0 for all cycles until new operands have flowed through.
- Positive operands held 8+ cycles each:
  - 1*1 -> 1
  - 8*3 -> 24
  - 15*15 -> 225
  - 56*25 -> 1400
  - 127*127 -> 16129
  - 100*10 -> 1000
  - 42*10 -> 420
- Signs and zeros:
  - -1*-1 -> 1
  - -1*1 -> -1 (15'h7FFF)
  - 1*-1 -> -1
  - -128*1 -> -128
  - -86*85 -> -7310
  - 85*-86 -> -7310
  - 0*0, 1*0 and 0*1 -> 0
- Wrap corner: -128*-128 -> o_mul = 15'h4000.
- Latency/throughput:
  - Drive a new pair every cycle (e.g. 4*3, 11*6, 2*2).
  - Required: 12, 66, 4 appear on 3 consecutive cycles, the first exactly 8 edges after sampling.
  - Random back-to-back streams must match a reference model shifted by 8 cycles.
- Mid-stream reset: assert rst for 1 cycle while 3 products are in flight -> o_mul is 0 on the next cycle, with no stale product emitted afterwards.
